// File: rtl/dm_resp_pkg.sv
// dm_resp_pkg: shared state encoding, funct3 codes and alignment helper for the data-memory responder.
package dm_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} dm_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3 == F3_B || f3 == F3_BU) ? 1'b0 :
           (f3 == F3_H || f3 == F3_HU) ? a[0] :
           (f3 == F3_W) ? (a != 2'b00) : 1'b0;
  endfunction
endpackage

// File: rtl/dm_sram_array.sv
// dm_sram_array: DEPTH x 32 word store with byte write enables and a registered read port.
module dm_sram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  // Read-first: the returned word is the contents before this edge's write.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < 4; i++)
        if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      o_rdata <= r_mem[i_addr];
    end
  end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder that stalls the CPU for LATENCY cycles per access,
// then performs the load/store against an internal word array and flags faulting accesses.
module dm_responder
  import dm_resp_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] D_Addr,
  input  logic        D_Read,
  input  logic [3:0]  D_Write,
  input  logic [31:0] D_WrtieData,
  input  logic [2:0]  D_type,
  output logic [31:0] D_ReadData,
  output logic        NOP,
  output logic        err
);
  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [32:0] LIM = {1'b0, BASE} + 33'(DEPTH) * 33'd4;
  if (LATENCY < 1) begin : g_lat_chk
    $error("dm_responder: LATENCY must be at least 1");
  end
  dm_state_e      r_state, w_next;
  logic [CW-1:0]  r_cnt, w_cnt;
  logic           r_zero, r_err;
  logic           w_req, w_go, w_oor, w_mis, w_both;
  logic [31:0]    w_off, w_rdata;
  logic [AW-1:0]  w_idx;
  assign w_req  = D_Read | (|D_Write);
  assign w_off  = D_Addr - BASE;
  assign w_idx  = AW'(w_off >> 2);
  assign w_oor  = (D_Addr < BASE) || ({1'b0, D_Addr} >= LIM);
  assign w_mis  = misaligned(D_type, D_Addr[1:0]);
  assign w_both = D_Read & (|D_Write);
  assign w_go   = (w_next == DONE);
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    NOP    = 1'b0;
    case (r_state)
      IDLE: begin
        NOP    = w_req;
        w_next = !w_req ? IDLE : (LATENCY == 1) ? DONE : WAIT;
        w_cnt  = w_req ? CW'(LATENCY > 1 ? LATENCY - 2 : 0) : r_cnt;
      end
      WAIT: begin
        NOP    = 1'b1;
        w_next = (r_cnt == '0) ? DONE : WAIT;
        w_cnt  = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_zero  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_err   <= w_go & (w_oor | w_mis | w_both);
      if (w_go) r_zero <= w_oor | w_both;
    end
  end
  // Out-of-range accesses never touch the array, so aliasing into it is impossible.
  dm_sram_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .i_en    (w_go & ~w_oor),
    .i_we    (D_Write),
    .i_addr  (w_idx),
    .i_wdata (D_WrtieData),
    .o_rdata (w_rdata)
  );
  assign D_ReadData = r_zero ? 32'h0 : w_rdata;
  assign err        = r_err;
endmodule
